// File: rtl/rx_idle_insertion.sv
// Receive-side rate compensation: elastic FIFO that emits one 64b/8b block per enabled cycle and
// refills removed-AM slots with IDLE blocks inserted ahead of an IDLE head. Optional: RX_IDLE_DELETE_EN.
module rx_idle_insertion #(
    parameter int LEN_RX_DATA = 64,
    parameter int LEN_RX_CTRL = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int PREFILL     = 8,
    parameter int LOW_TH      = 4,
    parameter int HIGH_TH     = 12
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_valid,
    input  logic [LEN_RX_DATA-1:0] i_rx_data,
    input  logic [LEN_RX_CTRL-1:0] i_rx_ctrl,
    output logic [LEN_RX_DATA-1:0] o_rx_data,
    output logic [LEN_RX_CTRL-1:0] o_rx_ctrl,
    output logic                   o_valid,
    output logic                   o_insert,
    output logic                   o_overflow,
    output logic                   o_underflow
`ifdef RX_IDLE_DELETE_EN
    ,
    output logic                   o_delete
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = LEN_RX_DATA + LEN_RX_CTRL;

    localparam logic [LEN_RX_DATA-1:0] IDLE_DATA = {(LEN_RX_DATA / 8){8'h07}};
    localparam logic [LEN_RX_CTRL-1:0] IDLE_CTRL = '1;
    localparam logic [BW-1:0]          IDLE_BLK  = {IDLE_DATA, IDLE_CTRL};

    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
    localparam logic [LW-1:0] LOW_L     = LW'(LOW_TH);
`ifdef RX_IDLE_DELETE_EN
    localparam logic [LW-1:0] HIGH_L    = LW'(HIGH_TH);
`endif

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rx_idle_insertion: FIFO_DEPTH must be a power of 2 and at least 4");
    end
    if (LOW_TH >= PREFILL) begin : g_bad_low
        $error("rx_idle_insertion: LOW_TH must be below PREFILL");
    end
    if (HIGH_TH <= LOW_TH || HIGH_TH >= FIFO_DEPTH) begin : g_bad_high
        $error("rx_idle_insertion: HIGH_TH must lie between LOW_TH and FIFO_DEPTH");
    end
    if (LEN_RX_DATA != 8 * LEN_RX_CTRL) begin : g_bad_width
        $error("rx_idle_insertion: one control bit per data byte expected");
    end

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [BW-1:0]   blk_q, blk_d;
    logic            valid_q, valid_d;
    logic            insert_q, insert_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
`ifdef RX_IDLE_DELETE_EN
    logic            del_q, del_d;
`endif

    logic [BW-1:0]   mem_q [FIFO_DEPTH];
    logic [BW-1:0]   head;
    logic            head_idle;
    logic            wr_en;
    logic [1:0]      pop_cnt;

    assign head      = mem_q[rd_ptr_q];
    assign head_idle = (head == IDLE_BLK);

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        valid_d  = valid_q;
        insert_d = 1'b0;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
`ifdef RX_IDLE_DELETE_EN
        del_d    = 1'b0;
`endif
        wr_en    = 1'b0;
        pop_cnt  = 2'd0;

        if (i_enable) begin
            wr_en = i_valid && (level_q != DEPTH_L);
            ovf_d = i_valid && (level_q == DEPTH_L);

            // FILL acts as RUN on the very cycle the prefill level is reached, so the first
            // block leaves without an idle cycle and a steady stream keeps the level at PREFILL.
            if (state_q == RUN || level_q >= PREFILL_L) begin
                state_d = RUN;
                valid_d = 1'b1;
                if (level_q == '0) begin
                    blk_d   = IDLE_BLK;
                    udf_d   = 1'b1;
                    state_d = FILL;
                end else if (level_q < LOW_L && head_idle) begin
                    blk_d    = IDLE_BLK;
                    insert_d = 1'b1;
`ifdef RX_IDLE_DELETE_EN
                end else if (level_q >= HIGH_L && head_idle) begin
                    del_d = 1'b1;
                    if (level_q >= LW'(2)) begin
                        pop_cnt = 2'd2;
                        blk_d   = mem_q[rd_ptr_q + AW'(1)];
                    end else begin
                        pop_cnt = 2'd1;
                        blk_d   = IDLE_BLK;
                    end
`endif
                end else begin
                    pop_cnt = 2'd1;
                    blk_d   = head;
                end
            end else begin
                valid_d = 1'b0;
            end
        end

        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop_cnt);
        level_d  = level_q + LW'(wr_en) - LW'(pop_cnt);
    end

    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {i_rx_data, i_rx_ctrl};
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            blk_q    <= IDLE_BLK;
            valid_q  <= 1'b0;
            insert_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
`ifdef RX_IDLE_DELETE_EN
            del_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            blk_q    <= blk_d;
            valid_q  <= valid_d;
            insert_q <= insert_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
`ifdef RX_IDLE_DELETE_EN
            del_q    <= del_d;
`endif
        end
    end

    assign o_rx_data   = blk_q[BW-1:LEN_RX_CTRL];
    assign o_rx_ctrl   = blk_q[LEN_RX_CTRL-1:0];
    assign o_valid     = valid_q;
    assign o_insert    = insert_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;
`ifdef RX_IDLE_DELETE_EN
    assign o_delete    = del_q;
`endif

endmodule

// File: tb/tb_rx_idle_insertion.sv
// Directed bench for rx_idle_insertion: fill, streaming, drain/underflow, hole refill, frame integrity,
// overflow (second instance whose prefill level is unreachable, so it never leaves FILL).
module tb_rx_idle_insertion;

    localparam logic [63:0] IDLE_D = 64'h0707_0707_0707_0707;
    localparam logic [7:0]  IDLE_C = 8'hFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, vld;
    logic [63:0] din;
    logic [7:0]  cin;
    logic [63:0] dout;
    logic [7:0]  cout;
    logic        ovalid, oins, oovf, oudf;

    logic        ov_en, ov_vld;
    logic [63:0] ov_din;
    logic [7:0]  ov_cin;
    logic [63:0] ov_dout;
    logic [7:0]  ov_cout;
    logic        ov_valid, ov_ins, ov_ovf, ov_udf;
`ifdef RX_IDLE_DELETE_EN
    logic        odel, ov_del;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_idle_insertion dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_enable    (en),
        .i_valid     (vld),
        .i_rx_data   (din),
        .i_rx_ctrl   (cin),
        .o_rx_data   (dout),
        .o_rx_ctrl   (cout),
        .o_valid     (ovalid),
        .o_insert    (oins),
        .o_overflow  (oovf),
        .o_underflow (oudf)
`ifdef RX_IDLE_DELETE_EN
        ,
        .o_delete    (odel)
`endif
    );

    rx_idle_insertion #(
        .PREFILL (17)
    ) dut_ovf (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_enable    (ov_en),
        .i_valid     (ov_vld),
        .i_rx_data   (ov_din),
        .i_rx_ctrl   (ov_cin),
        .o_rx_data   (ov_dout),
        .o_rx_ctrl   (ov_cout),
        .o_valid     (ov_valid),
        .o_insert    (ov_ins),
        .o_overflow  (ov_ovf),
        .o_underflow (ov_udf)
`ifdef RX_IDLE_DELETE_EN
        ,
        .o_delete    (ov_del)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [63:0] ed,
                           input logic [7:0] ec, input logic ei);
        chk({tag, ".valid"}, 64'(ovalid), 64'(ev));
        chk({tag, ".data"}, dout, ed);
        chk({tag, ".ctrl"}, 64'(cout), 64'(ec));
        chk({tag, ".insert"}, 64'(oins), 64'(ei));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] dblk(input int k);
        return 64'hD000_0000_0000_0000 | 64'(k);
    endfunction

    // Frame: 1 = start, 2..11 = payload, 12 = terminate, 13 = IDLE, 0 = hole
    function automatic logic [71:0] fblk(input int k);
        if (k == 1)       return {64'hD555_5555_5555_55FB, 8'h01};
        else if (k == 12) return {64'h0707_0707_0707_07FD, 8'hFF};
        else if (k == 13) return {IDLE_D, IDLE_C};
        else              return {64'hA5A5_0000_0000_0000 | 64'(k), 8'h00};
    endfunction

    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] c);
        vld = v;
        din = d;
        cin = c;
    endtask

    initial begin
        int ucount;
        int bad_valid;
        int in_seq [23];
        int exp_seq[23];
        logic [71:0] b;

        en     = 1'b1;
        rst_n  = 1'b0;
        ov_en  = 1'b1;
        ov_vld = 1'b0;
        ov_din = '0;
        ov_cin = '0;

        // 1: reset with random inputs, then fill
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), {$urandom, $urandom}, 8'($urandom));
            tick();
        end
        chk_out("reset", 1'b0, IDLE_D, IDLE_C, 1'b0);
        chk("reset.ovf", 64'(oovf), 64'd0);
        chk("reset.udf", 64'(oudf), 64'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, dblk(k), 8'h00);
            tick();
            chk("fill.valid", 64'(ovalid), 64'd0);
        end

        // 2: continuous data stream passes through in order
        for (int k = 9; k <= 20; k++) begin
            drive(1'b1, dblk(k), 8'h00);
            tick();
            chk_out("stream", 1'b1, dblk(k - 8), 8'h00, 1'b0);
        end
        en = 1'b0;
        drive(1'b1, 64'hDEAD_BEEF_0000_0000, 8'h00);
        tick();
        chk_out("enable_off", 1'b1, dblk(12), 8'h00, 1'b0);
        chk("enable_off.ovf", 64'(oovf), 64'd0);
        en = 1'b1;

        // 5: input stops with data at head -> drain, one underflow, back to FILL
        ucount = 0;
        for (int t = 0; t < 20; t++) begin
            drive(1'b0, IDLE_D, IDLE_C);
            tick();
            if (oudf) ucount++;
            if (t < 8)   chk_out("drain", 1'b1, dblk(13 + t), 8'h00, 1'b0);
            if (t == 8) begin
                chk_out("underflow", 1'b1, IDLE_D, IDLE_C, 1'b0);
                chk("underflow.pulse", 64'(oudf), 64'd1);
            end
            if (t == 9)  chk("refill.valid", 64'(ovalid), 64'd0);
            if (t == 19) chk("refill.valid_late", 64'(ovalid), 64'd0);
        end
        chk("underflow.count", 64'(ucount), 64'd1);

        // 3: all-IDLE stream, one hole per 20 blocks; inserts start once level falls to 3
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, IDLE_D, IDLE_C);
            tick();
            chk("idlefill.valid", 64'(ovalid), 64'd0);
        end
        bad_valid = 0;
        for (int i = 0; i < 170; i++) begin
            drive(!((i % 20 == 19) && (i < 160)), IDLE_D, IDLE_C);
            tick();
            if (ovalid !== 1'b1) bad_valid++;
            chk("holes.insert", 64'(oins),
                64'((i == 100) || (i == 120) || (i == 140) || (i == 160)));
        end
        chk("holes.valid_gaps", 64'(bad_valid), 64'd0);
        chk_out("holes.end", 1'b1, IDLE_D, IDLE_C, 1'b0);

        // 4: reset mid-operation, then a frame with six holes inside it
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("midreset", 1'b0, IDLE_D, IDLE_C, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, IDLE_D, IDLE_C);
            tick();
            chk("frame_fill.valid", 64'(ovalid), 64'd0);
        end
        in_seq  = '{1, 0, 2, 0, 3, 0, 4, 0, 5, 0, 6, 0, 7, 8, 9, 10, 11, 12, 13, 13, 13, 13, 13};
        exp_seq = '{13, 13, 13, 13, 13, 13, 13, 13, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12,
                    14, 14, 13};
        for (int i = 0; i < 23; i++) begin
            b = fblk(in_seq[i]);
            drive(in_seq[i] != 0, b[71:8], b[7:0]);
            tick();
            b = fblk(exp_seq[i] == 14 ? 13 : exp_seq[i]);
            chk_out("frame", 1'b1, b[71:8], b[7:0], exp_seq[i] == 14);
        end

        // 6: overflow on the instance held in FILL
        for (int k = 1; k <= 17; k++) begin
            ov_vld = 1'b1;
            ov_din = dblk(100 + k);
            ov_cin = 8'h00;
            tick();
            chk("ovf.pulse", 64'(ov_ovf), 64'(k == 17));
        end
        ov_vld = 1'b0;
        tick();
        chk("ovf.clear", 64'(ov_ovf), 64'd0);
        chk("ovf.valid", 64'(ov_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
